// File: rtl/wb_dbg_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_dbg_master
// Description : Byte-stream debug command bridge issuing single 32-bit
//               pipelined Wishbone transfers and returning status/data bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_dbg_master #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  CMD_WRITE      = 8'h57,
    parameter logic [7:0]  CMD_READ       = 8'h52
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_stb_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        rx_drop_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_stall_i
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_WB_REQ  = 3'd3;
    localparam logic [2:0] S_WB_WAIT = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          we_q, we_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [39:0]   resp_q, resp_d;
    logic [2:0]    left_q, left_d;
    logic          drop_q, drop_d;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            tmo_q   <= '0;
            resp_q  <= '0;
            left_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            tmo_q   <= tmo_d;
            resp_q  <= resp_d;
            left_q  <= left_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        tmo_d   = tmo_q;
        resp_d  = resp_q;
        left_d  = left_q;
        drop_d  = drop_q;

        if (rx_stb_i && (state_q == S_WB_REQ || state_q == S_WB_WAIT || state_q == S_RESP))
            drop_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (rx_stb_i) begin
                    cnt_d = 2'd0;
                    if (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ) begin
                        we_d    = (rx_data_i == CMD_WRITE);
                        state_d = S_ADDR;
                    end else begin
                        resp_d  = {8'h3F, 32'h0};
                        left_d  = 3'd1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_stb_i) begin
                    adr_d = {adr_q[23:0], rx_data_i};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        tmo_d   = '0;
                        state_d = we_q ? S_DATA : S_WB_REQ;
                    end
                end
            end
            S_DATA: begin
                if (rx_stb_i) begin
                    dat_d = {dat_q[23:0], rx_data_i};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        tmo_d   = '0;
                        state_d = S_WB_REQ;
                    end
                end
            end
            S_WB_REQ, S_WB_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                // Completion is only meaningful once the strobe has been taken.
                if ((state_q == S_WB_WAIT || !wbm_stall_i) && wbm_err_i) begin
                    resp_d  = {8'h45, 32'h0};
                    left_d  = 3'd1;
                    state_d = S_RESP;
                end else if ((state_q == S_WB_WAIT || !wbm_stall_i) && wbm_ack_i) begin
                    resp_d  = we_q ? {8'h4B, 32'h0} : {8'h44, wbm_dat_i};
                    left_d  = we_q ? 3'd1 : 3'd5;
                    state_d = S_RESP;
                end else if (tmo_q == C_TMO_LAST) begin
                    resp_d  = {8'h54, 32'h0};
                    left_d  = 3'd1;
                    state_d = S_RESP;
                end else if (state_q == S_WB_REQ && !wbm_stall_i) begin
                    state_d = S_WB_WAIT;
                end
            end
            S_RESP: begin
                if (tx_ready_i) begin
                    resp_d = {resp_q[31:0], 8'h00};
                    left_d = left_q - 3'd1;
                    if (left_q == 3'd1)
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wbm_cyc_o  = (state_q == S_WB_REQ) || (state_q == S_WB_WAIT);
        wbm_stb_o  = (state_q == S_WB_REQ);
        wbm_we_o   = wbm_cyc_o && we_q;
        wbm_adr_o  = adr_q;
        wbm_dat_o  = dat_q;
        wbm_sel_o  = 4'hF;
        tx_valid_o = (state_q == S_RESP);
        tx_data_o  = resp_q[39:32];
        busy_o     = (state_q != S_IDLE);
        rx_drop_o  = drop_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_dbg_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_dbg_master
// Description : Self-checking bench for wb_dbg_master with a Wishbone slave
//               model and a command-level response reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_dbg_master;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_stb = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        rx_drop;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_o;
    logic [3:0]  sel;
    logic [31:0] dat_i = 32'h0;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic        stall = 1'b0;

    int          ncmp = 0;
    int          nerr = 0;
    logic        exp_drop = 1'b0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    wb_dbg_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .rx_data_i(rx_data), .rx_stb_i(rx_stb),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .busy_o(busy), .rx_drop_o(rx_drop),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel),
        .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(err), .wbm_stall_i(stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        rx_data = b;
        rx_stb  = 1'b1;
        @(negedge clk);
        rx_stb  = 1'b0;
    endtask

    task automatic send_cmd(input bit w, input logic [31:0] a, input logic [31:0] d);
        send_byte(w ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
        if (w) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
    endtask

    // kind: 0 ack, 1 err, 2 timeout, 3 unknown command
    task automatic model_resp(input int kind, input bit w, input logic [31:0] rd);
        exp_q.delete();
        case (kind)
            0: begin
                if (w) exp_q.push_back(8'h4B);
                else begin
                    exp_q.push_back(8'h44);
                    for (int i = 3; i >= 0; i--) exp_q.push_back(8'((rd >> (8 * i)) & 32'hFF));
                end
            end
            1: exp_q.push_back(8'h45);
            2: exp_q.push_back(8'h54);
            default: exp_q.push_back(8'h3F);
        endcase
    endtask

    task automatic bus_slave(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input int stalls, input int delay, input int kind,
                             input bit ack_too, input logic [31:0] rd);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (stb) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("stb_seen", 64'(found), 64'd1);
        if (!found) return;
        chk("cyc_at_stb", 64'(cyc), 64'd1);
        chk("adr", 64'(adr), 64'(a));
        chk("we", 64'(we), 64'(w));
        chk("sel", 64'(sel), 64'hF);
        if (w) chk("wdat", 64'(dat_o), 64'(d));
        stall = (stalls > 0);
        if (kind == 2) begin
            for (int k = 1; k <= TMO; k++) begin
                @(negedge clk);
                stall = (k < stalls);
                if (k == TMO - 1) chk("tmo_cyc_before", 64'(cyc), 64'd1);
                if (k == TMO) chk("tmo_cyc_after", 64'({cyc, stb}), 64'd0);
            end
            ack   = 1'b1;
            dat_i = $urandom;
            @(negedge clk);
            ack   = 1'b0;
            return;
        end
        for (int j = 1; j <= stalls; j++) begin
            @(negedge clk);
            chk("stb_held", 64'({stb, cyc}), 64'h3);
            chk("adr_stable", 64'(adr), 64'(a));
            stall = (j < stalls);
        end
        stall = 1'b0;
        if (delay > 0) begin
            @(negedge clk);
            chk("wait_cyc_stb", 64'({cyc, stb}), 64'h2);
            repeat (delay - 1) @(negedge clk);
        end
        if (kind == 1) begin
            err = 1'b1;
            ack = ack_too;
        end else begin
            ack = 1'b1;
        end
        dat_i = rd;
        @(negedge clk);
        ack   = 1'b0;
        err   = 1'b0;
        dat_i = $urandom;
        chk("cyc_dropped", 64'({cyc, stb}), 64'd0);
    endtask

    task automatic collect();
        logic [7:0] got_q[$];
        logic [7:0] pd = 8'h00;
        bit         pv = 1'b0;
        for (int c = 0; c < 300 && got_q.size() < exp_q.size(); c++) begin
            if (c > 0) @(negedge clk);
            if (pv) chk("tx_hold", 64'({tx_valid, tx_data}), 64'({1'b1, pd}));
            tx_ready = ($urandom_range(0, 2) != 0);
            if (tx_valid) begin
                if (tx_ready) got_q.push_back(tx_data);
                pv = !tx_ready;
                pd = tx_data;
            end else begin
                pv = 1'b0;
            end
        end
        chk("resp_len", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk("resp_byte", 64'(got_q[i]), 64'(exp_q[i]));
        @(negedge clk);
        tx_ready = 1'b0;
        chk("idle_after_resp", 64'({busy, tx_valid}), 64'd0);
        chk("rx_drop", 64'(rx_drop), 64'(exp_drop));
    endtask

    task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input int stalls, input int delay, input int kind,
                           input bit ack_too, input logic [31:0] rd);
        send_cmd(w, a, d);
        model_resp(kind, w, rd);
        bus_slave(w, a, d, stalls, delay, kind, ack_too, rd);
        collect();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rd_v, wd;
        int          kind;
        bit          w;

        repeat (3) @(negedge clk);
        chk("rst_bus", 64'({cyc, stb, we}), 64'd0);
        chk("rst_adr", 64'(adr), 64'd0);
        chk("rst_dat", 64'(dat_o), 64'd0);
        chk("rst_sel", 64'(sel), 64'hF);
        chk("rst_tx", 64'({tx_valid, tx_data}), 64'd0);
        chk("rst_status", 64'({busy, rx_drop}), 64'd0);
        rst = 1'b0;

        run_txn(1'b1, 32'h02000000, 32'h000000A5, 0, 1, 0, 1'b0, 32'h0);
        run_txn(1'b0, 32'h01000010, 32'h0, 2, 0, 0, 1'b0, 32'hDEADBEEF);
        run_txn(1'b1, 32'h00001000, 32'h12345678, 0, 1, 1, 1'b1, 32'h0);
        run_txn(1'b0, 32'h00002000, 32'h0, 0, 0, 2, 1'b0, 32'h0);

        // Unknown byte, then a dropped rx byte while the response is held back.
        send_byte(8'h00);
        model_resp(3, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx_stb  = (i == 0);
            rx_data = 8'h57;
            chk("hold_tx", 64'({tx_valid, tx_data}), 64'({1'b1, 8'h3F}));
            chk("bad_no_bus", 64'(cyc), 64'd0);
        end
        rx_stb   = 1'b0;
        exp_drop = 1'b1;
        chk("drop_set", 64'(rx_drop), 64'd1);
        collect();

        // Reset while a read waits for its acknowledge.
        send_cmd(1'b0, 32'hCAFE0000, 32'h0);
        for (int i = 0; i < 40 && !stb; i++) @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        chk("pre_rst_wait", 64'({cyc, stb}), 64'h2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst", 64'({cyc, stb, tx_valid, busy, rx_drop}), 64'd0);
        rst      = 1'b0;
        exp_drop = 1'b0;
        run_txn(1'b0, 32'h00000040, 32'h0, 1, 2, 0, 1'b0, 32'h0BADF00D);

        for (int n = 0; n < 25; n++) begin
            w    = $urandom_range(0, 1) == 1;
            ra   = $urandom;
            wd   = $urandom;
            rd_v = $urandom;
            case ($urandom_range(0, 9))
                0:       kind = 1;
                1:       kind = 2;
                default: kind = 0;
            endcase
            run_txn(w, ra, wd, $urandom_range(0, 3), $urandom_range(0, 3), kind,
                    $urandom_range(0, 1) == 1, rd_v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
`default_nettype wire
